// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, polarity normalisation and FSM/counter bounce filter.
// Define DEBOUNCE_BYPASS_EN to compile out the filter (key_clean = synchronised input, bouncing = 0).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter int ACTIVE_LOW_IN   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_clean,
    output logic bouncing
);

    logic p_raw;
    logic s1;
    logic s2;

    assign p_raw = (ACTIVE_LOW_IN != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= p_raw;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_BYPASS_EN

    assign key_clean = s2;
    assign bouncing  = 1'b0;

`else

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_PEND   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_PEND = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The terminal-count compare precedes the increment, so cnt never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            RELEASED: begin
                if (s2) begin
                    state_next = PRESS_PEND;
                    cnt_next   = CNT_WIDTH'(1);
                end
            end
            PRESS_PEND: begin
                if (!s2) begin
                    state_next = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = RELEASE_PEND;
                    cnt_next   = CNT_WIDTH'(1);
                end
            end
            RELEASE_PEND: begin
                if (s2) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

    always_comb begin
        key_clean = state[1];
        bouncing  = (state == PRESS_PEND) || (state == RELEASE_PEND);
    end

`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: two instances (active-low D=4, active-high D=3) against a run-length model.
// Scripted press/release/glitch/reset scenarios followed by randomized bouncy stimulus.
module tb_key_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_raw0 = 1'b1;
    logic key_raw1 = 1'b0;
    logic key_clean0, bouncing0;
    logic key_clean1, bouncing1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance: synchroniser pipeline, accepted level, disagreeing-sample run.
    int   dcyc [2] = '{4, 3};
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_clean [2];
    int   m_run [2];

    always #5 clk = ~clk;

    key_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW_IN(1)) dut0 (
        .clk(clk), .reset(reset), .key_raw(key_raw0), .key_clean(key_clean0), .bouncing(bouncing0)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(3), .CNT_WIDTH(2), .ACTIVE_LOW_IN(0)) dut1 (
        .clk(clk), .reset(reset), .key_raw(key_raw1), .key_clean(key_clean1), .bouncing(bouncing1)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // A level is accepted once the sampled input has disagreed with it for D consecutive samples.
    task automatic model_edge(input int i, input logic rst, input logic pressed);
        if (rst) begin
            m_s1[i] = 1'b0;
            m_s2[i] = 1'b0;
            m_clean[i] = 1'b0;
            m_run[i] = 0;
        end else begin
`ifdef DEBOUNCE_BYPASS_EN
            m_clean[i] = m_s1[i];
            m_run[i] = 0;
`else
            if (m_s2[i] != m_clean[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == dcyc[i]) begin
                    m_clean[i] = ~m_clean[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
`endif
            m_s2[i] = m_s1[i];
            m_s1[i] = pressed;
        end
    endtask

    // One clock: drive inputs (logical press levels), advance model at the edge, compare #1 later.
    task automatic step(input logic rst, input logic p0, input logic p1);
        reset    = rst;
        key_raw0 = ~p0;
        key_raw1 = p1;
        @(posedge clk);
        model_edge(0, rst, p0);
        model_edge(1, rst, p1);
        #1;
        check("clean0", key_clean0, m_clean[0]);
        check("bounce0", bouncing0, m_run[0] != 0);
        check("clean1", key_clean1, m_clean[1]);
        check("bounce1", bouncing1, m_run[1] != 0);
    endtask

    initial begin
        int   hold0 = 0;
        int   hold1 = 0;
        logic lvl0 = 1'b0;
        logic lvl1 = 1'b0;
        logic rst_r;
        logic exp_c;
        logic exp_b;

        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_clean[i] = 1'b0; m_run[i] = 0;
        end
        #2;

        // Reset, then key released for 20 cycles.
        step(1'b1, 1'b0, 1'b0);
        check("rst_clean", key_clean0, 1'b0);
        check("rst_bounce", bouncing0, 1'b0);
        for (int e = 0; e < 20; e++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle_clean", key_clean0, 1'b0);
            check("idle_bounce", bouncing0, 1'b0);
        end

        // Clean press: qualification timing.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b1, 1'b1);
`ifdef DEBOUNCE_BYPASS_EN
            exp_c = (e >= 1);
            exp_b = 1'b0;
`else
            exp_c = (e >= 5);
            exp_b = (e >= 2) && (e <= 4);
`endif
            check("press_clean", key_clean0, exp_c);
            check("press_bounce", bouncing0, exp_b);
        end

`ifndef DEBOUNCE_BYPASS_EN
        // Two-cycle release blip while pressed is rejected.
        for (int e = 0; e < 10; e++) begin
            step(1'b0, e >= 2, e >= 2);
            check("blip_clean", key_clean0, 1'b1);
        end
`endif

        // Clean release.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_BYPASS_EN
            exp_c = (e < 1);
`else
            exp_c = (e < 5);
`endif
            check("release_clean", key_clean0, exp_c);
        end

`ifndef DEBOUNCE_BYPASS_EN
        // Three-cycle press glitch from released is rejected; bouncing rises then falls.
        for (int e = 0; e < 10; e++) begin
            step(1'b0, e < 3, e < 3);
            check("glitch_clean", key_clean0, 1'b0);
            check("glitch_bounce", bouncing0, (e >= 2) && (e <= 4));
        end
`endif

        // Reset while qualifying a held key, then fresh qualification.
        for (int e = 0; e < 3; e++) step(1'b0, 1'b1, 1'b1);
`ifndef DEBOUNCE_BYPASS_EN
        check("pre_rst_bounce", bouncing0, 1'b1);
`endif
        step(1'b1, 1'b1, 1'b1);
        check("midrst_clean", key_clean0, 1'b0);
        check("midrst_bounce", bouncing0, 1'b0);
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b1, 1'b1);
`ifdef DEBOUNCE_BYPASS_EN
            exp_c = (e >= 1);
`else
            exp_c = (e >= 5);
`endif
            check("requal_clean", key_clean0, exp_c);
        end

        // Randomized bouncy stimulus with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (hold0 == 0) begin
                lvl0  = 1'($urandom_range(0, 1));
                hold0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 4));
            end
            if (hold1 == 0) begin
                lvl1  = 1'($urandom_range(0, 1));
                hold1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(1, 3));
            end
            hold0--;
            hold1--;
            rst_r = ($urandom_range(0, 79) == 0);
            step(rst_r, lvl0, lvl1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
